// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: tag field layout, op/target codes and the
// responder state encoding, used by both the memory responder and the fetch initiator.
package sysbus_pkg;

   localparam int TAG_OP_BIT = 12;
   localparam int TAG_TGT_HI = 11;
   localparam int TAG_TGT_LO = 8;

   localparam logic       OP_READ  = 1'b1;
   localparam logic       OP_WRITE = 1'b0;
   localparam logic [3:0] TGT_MEM  = 4'h1;

   localparam int BEATS_PER_LINE = 8;

   typedef enum logic [1:0] {
      IDLE,
      WDATA,
      WAIT,
      RESP
   } sysbusState_t;

endpackage

// File: rtl/sysbus_mem_responder_mem_array.sv
// Single-port backing store with a registered (one-cycle) read port.
// Contents are deliberately not reset so data survives a bus reset.
module mem_array #(
   parameter int WIDTH  = 64,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 12
)(
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WIDTH-1:0]  i_wdata,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      o_rdata <= r_mem[i_addr];
   end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Line-oriented memory responder on the system bus: accepts one tagged request,
// then streams or absorbs an 8-beat cache line against the backing store.
module sysbus_mem_responder
   import sysbus_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int MEM_WORDS      = 4096,
   parameter int LATENCY        = 4
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_reqack,
   output logic                      bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      bus_respack
);

   localparam int AW    = $clog2(MEM_WORDS);
   localparam int LAT_W = $clog2(LATENCY + 1);
   localparam logic [2:0]       BEAT_LAST = 3'(BEATS_PER_LINE - 1);
   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATENCY - 1);

   sysbusState_t r_state, w_nextState;
   logic                     r_reqack, w_nextReqack;
   logic [2:0]               r_beat, w_nextBeat;
   logic [LAT_W-1:0]         r_lat, w_nextLat;
   logic [AW-4:0]            r_line, w_nextLine;
   logic [BUS_TAG_WIDTH-1:0] r_tag, w_nextTag;
   logic                     w_memWe;
   logic                     w_isMem;
   logic                     w_respcyc;
   logic [AW-1:0]            w_memAddr;
   logic [BUS_DATA_WIDTH-1:0] w_memRdata;

   assign w_isMem = (r_tag[TAG_TGT_HI:TAG_TGT_LO] == TGT_MEM);

   // The RAM address always points at the word that must be visible on the bus
   // next cycle, so its one-cycle read lines up with the beat being presented.
   always_comb begin
      w_nextState  = r_state;
      w_nextReqack = 1'b0;
      w_nextBeat   = r_beat;
      w_nextLat    = r_lat;
      w_nextLine   = r_line;
      w_nextTag    = r_tag;
      w_memWe      = 1'b0;
      w_memAddr    = {r_line, r_beat};
      case (r_state)
         IDLE: begin
            if (bus_reqcyc) begin
               w_nextLine   = bus_req[AW+2:6];
               w_nextTag    = bus_reqtag;
               w_nextReqack = 1'b1;
               w_nextBeat   = 3'd0;
               w_nextLat    = '0;
               w_nextState  = (bus_reqtag[TAG_OP_BIT] == OP_READ) ? WAIT : WDATA;
            end
         end
         WDATA: begin
            if (bus_reqcyc) begin
               w_memWe    = w_isMem && !reset;
               w_nextBeat = r_beat + 3'd1;
               if (r_beat == BEAT_LAST) begin
                  w_nextState = IDLE;
               end
            end
         end
         WAIT: begin
            if (r_lat == LAT_LAST) begin
               w_nextState = RESP;
            end else begin
               w_nextLat = r_lat + LAT_W'(1);
            end
         end
         RESP: begin
            if (bus_respack) begin
               w_nextBeat = r_beat + 3'd1;
               w_memAddr  = {r_line, r_beat + 3'd1};
               if (r_beat == BEAT_LAST) begin
                  w_nextState = IDLE;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_reqack <= 1'b0;
         r_beat   <= 3'd0;
         r_lat    <= '0;
         r_tag    <= '0;
         r_line   <= '0;
      end else begin
         r_state  <= w_nextState;
         r_reqack <= w_nextReqack;
         r_beat   <= w_nextBeat;
         r_lat    <= w_nextLat;
         r_tag    <= w_nextTag;
         r_line   <= w_nextLine;
      end
   end

   mem_array #(
      .WIDTH  (BUS_DATA_WIDTH),
      .DEPTH  (MEM_WORDS),
      .ADDR_W (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_memWe),
      .i_addr  (w_memAddr),
      .i_wdata (bus_req),
      .o_rdata (w_memRdata)
   );

   // Non-memory targets stream zeros with normal timing.
   assign w_respcyc   = (r_state == RESP);
   assign bus_reqack  = r_reqack;
   assign bus_respcyc = w_respcyc;
   assign bus_resp    = (w_respcyc && w_isMem) ? w_memRdata : '0;
   assign bus_resptag = w_respcyc ? r_tag : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed self-checking bench for sysbus_mem_responder: line writes/reads,
// respack stalls, address wrap, non-memory targets, reset abort and busy requests.
module tb_sysbus_mem_responder;

   localparam int LATENCY   = 4;
   localparam int MEM_WORDS = 4096;

   logic        clk;
   logic        reset;
   logic        bus_reqcyc;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_reqack;
   logic        bus_respcyc;
   logic [63:0] bus_resp;
   logic [12:0] bus_resptag;
   logic        bus_respack;

   int totalChecks = 0;
   int badChecks   = 0;

   sysbus_mem_responder #(
      .BUS_DATA_WIDTH (64),
      .BUS_TAG_WIDTH  (13),
      .MEM_WORDS      (MEM_WORDS),
      .LATENCY        (LATENCY)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respcyc (bus_respcyc),
      .bus_resp    (bus_resp),
      .bus_resptag (bus_resptag),
      .bus_respack (bus_respack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
      totalChecks++;
      assert (observed === expected) else begin
         badChecks++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
      end
   endtask

   // One-cycle request pulse; leaves the bench in the ack cycle.
   task automatic applyStimulus(input logic [63:0] addr, input logic [12:0] tag, input string name);
      bus_reqcyc = 1'b1;
      bus_req    = addr;
      bus_reqtag = tag;
      tick();
      checkOutput({name, "_ack"}, 64'(bus_reqack), 64'd1);
      bus_reqcyc = 1'b0;
      bus_req    = '0;
      bus_reqtag = '0;
   endtask

   // Called in the ack cycle: checks first-beat latency, 8 beats and the idle tail.
   task automatic collectBeats(input logic [12:0] tag, input logic [63:0] first, input logic [63:0] step,
                               input bit toggle, input string name);
      int n = 0;
      while (bus_respcyc !== 1'b1 && n < 32) begin
         tick();
         n++;
      end
      checkOutput({name, "_latency"}, 64'(n), 64'(LATENCY));
      if (bus_respcyc === 1'b1) begin
         for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s_d%0d", name, k), bus_resp, first + 64'(k) * step);
            checkOutput($sformatf("%s_t%0d", name, k), 64'(bus_resptag), 64'(tag));
            if (toggle) begin
               bus_respack = 1'b0;
               tick();
               checkOutput($sformatf("%s_hold%0d", name, k), bus_resp, first + 64'(k) * step);
            end
            bus_respack = 1'b1;
            tick();
         end
         bus_respack = 1'b0;
         checkOutput({name, "_endcyc"}, 64'(bus_respcyc), 64'd0);
         checkOutput({name, "_endresp"}, bus_resp, 64'd0);
         checkOutput({name, "_endtag"}, 64'(bus_resptag), 64'd0);
      end
   endtask

   task automatic readLine(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] first,
                           input logic [63:0] step, input bit toggle, input string name);
      applyStimulus(addr, tag, name);
      collectBeats(tag, first, step, toggle, name);
   endtask

   task automatic writeLine(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] first,
                            input logic [63:0] step, input int gapAfter, input string name);
      applyStimulus(addr, tag, name);
      for (int k = 0; k < 8; k++) begin
         bus_reqcyc = 1'b1;
         bus_req    = first + 64'(k) * step;
         tick();
         if (k == 0) checkOutput({name, "_ackdrop"}, 64'(bus_reqack), 64'd0);
         if (k == gapAfter) begin
            bus_reqcyc = 1'b0;
            bus_req    = 64'hFFFF_FFFF_FFFF_FFFF;
            tick();
            tick();
         end
      end
      bus_reqcyc = 1'b0;
      bus_req    = '0;
      checkOutput({name, "_noresp"}, 64'(bus_respcyc), 64'd0);
   endtask

   initial begin
      reset       = 1'b1;
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      tick();
      tick();
      checkOutput("rst_ack", 64'(bus_reqack), 64'd0);
      checkOutput("rst_respcyc", 64'(bus_respcyc), 64'd0);
      checkOutput("rst_resp", bus_resp, 64'd0);
      checkOutput("rst_tag", 64'(bus_resptag), 64'd0);
      reset = 1'b0;
      tick();

      $display("[TB] preload line 0 and basic reads");
      writeLine(64'h0, 13'h0101, 64'h11, 64'h11, -1, "wr0");
      readLine(64'h0, 13'h1105, 64'h11, 64'h11, 1'b0, "rd0");
      readLine(64'h0, 13'h1106, 64'h11, 64'h11, 1'b1, "rd0tog");

      $display("[TB] write with stall gap, read back, wrap");
      writeLine(64'h40, 13'h0102, 64'hA0, 64'h1, 3, "wr40");
      readLine(64'h40, 13'h1107, 64'hA0, 64'h1, 1'b0, "rd40");
      readLine(64'h8 + 64'(MEM_WORDS) * 64'd8, 13'h1108, 64'h11, 64'h11, 1'b0, "wrap");

      $display("[TB] non-memory target");
      writeLine(64'h0, 13'h0203, 64'hDEAD, 64'h1, -1, "wrnm");
      readLine(64'h0, 13'h1209, 64'h0, 64'h0, 1'b0, "rdnm");
      readLine(64'h0, 13'h110A, 64'h11, 64'h11, 1'b0, "rdkeep");

      $display("[TB] reset during beat 4");
      applyStimulus(64'h40, 13'h110B, "rstrd");
      begin
         int n = 0;
         while (bus_respcyc !== 1'b1 && n < 32) begin
            tick();
            n++;
         end
         checkOutput("rstrd_latency", 64'(n), 64'(LATENCY));
      end
      bus_respack = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      checkOutput("rstrd_beat4", bus_resp, 64'hA4);
      reset = 1'b1;
      tick();
      checkOutput("rstrd_respcyc", 64'(bus_respcyc), 64'd0);
      checkOutput("rstrd_resp", bus_resp, 64'd0);
      checkOutput("rstrd_ack", 64'(bus_reqack), 64'd0);
      reset       = 1'b0;
      bus_respack = 1'b0;
      tick();
      readLine(64'h40, 13'h110C, 64'hA0, 64'h1, 1'b0, "afterrst");

      $display("[TB] request while busy");
      applyStimulus(64'h0, 13'h110D, "busy");
      begin
         int n = 0;
         while (bus_respcyc !== 1'b1 && n < 32) begin
            tick();
            n++;
         end
         checkOutput("busy_latency", 64'(n), 64'(LATENCY));
      end
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("busy_d%0d", k), bus_resp, 64'h11 * 64'(k + 1));
         if (k == 2) begin
            bus_reqcyc = 1'b1;
            bus_req    = 64'h40;
            bus_reqtag = 13'h110E;
         end
         bus_respack = 1'b1;
         tick();
         if (k >= 2) checkOutput($sformatf("busy_noack%0d", k), 64'(bus_reqack), 64'd0);
      end
      bus_respack = 1'b0;
      checkOutput("busy_endcyc", 64'(bus_respcyc), 64'd0);
      tick();
      checkOutput("pend_ack", 64'(bus_reqack), 64'd1);
      bus_reqcyc = 1'b0;
      bus_req    = '0;
      bus_reqtag = '0;
      collectBeats(13'h110E, 64'hA0, 64'h1, 1'b0, "pend");

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
